// File: rtl/mux4_pkg.sv
// Shared channel indices and select type for the 4-channel round-robin feed stage.
package mux4_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t CH_A = 2'd0;
    localparam sel_t CH_B = 2'd1;
    localparam sel_t CH_C = 2'd2;
    localparam sel_t CH_D = 2'd3;

    function automatic logic [NUM_CH-1:0] sel_onehot(input sel_t sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 n-bit data mux, select 0..3 picks d0..d3.
module mux4 #(
    parameter int BUS_WIDTH = 8
) (
    input  logic [BUS_WIDTH-1:0] d0,
    input  logic [BUS_WIDTH-1:0] d1,
    input  logic [BUS_WIDTH-1:0] d2,
    input  logic [BUS_WIDTH-1:0] d3,
    input  logic [1:0]           sel,
    output logic [BUS_WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin search starting at ptr; first requester wins.
module rr_arb4
    import mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  sel_t              ptr,
    output sel_t              gnt_idx,
    output logic              gnt_any
);

    always_comb begin
        sel_t idx;
        gnt_idx = ptr;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = ptr + sel_t'(k);
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arb_reg.sv
// Four valid/ready producers arbitrated round-robin into one registered output slot.
// Optional per-channel saturating grant counters with MUX4_RR_GRANT_CNT_EN.
module mux4_rr_arb_reg
    import mux4_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    input  logic                 a_valid,
    input  logic                 b_valid,
    input  logic                 c_valid,
    input  logic                 d_valid,
    output logic                 a_ready,
    output logic                 b_ready,
    output logic                 c_ready,
    output logic                 d_ready,
    output logic [BUS_WIDTH-1:0] y,
    output logic [1:0]           y_sel,
    output logic                 y_valid,
`ifdef MUX4_RR_GRANT_CNT_EN
    output logic [31:0]          grant_cnt,
`endif
    input  logic                 y_ready
);

    sel_t                 ptr;
    sel_t                 gnt_idx;
    logic                 gnt_any;
    logic                 load;
    logic [NUM_CH-1:0]    rdy;
    logic [BUS_WIDTH-1:0] mux_y;

    rr_arb4 u_arb (
        .req     ({d_valid, c_valid, b_valid, a_valid}),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    mux4 #(.BUS_WIDTH(BUS_WIDTH)) u_mux (
        .d0  (a),
        .d1  (b),
        .d2  (c),
        .d3  (d),
        .sel (gnt_idx),
        .y   (mux_y)
    );

    // Gating with rst_n keeps producers from seeing a handshake that reset will drop.
    assign load = rst_n & (~y_valid | y_ready) & gnt_any;
    assign rdy  = load ? sel_onehot(gnt_idx) : '0;

    assign a_ready = rdy[CH_A];
    assign b_ready = rdy[CH_B];
    assign c_ready = rdy[CH_C];
    assign d_ready = rdy[CH_D];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y       <= '0;
            y_sel   <= CH_A;
            y_valid <= 1'b0;
            ptr     <= CH_A;
        end else if (load) begin
            y       <= mux_y;
            y_sel   <= gnt_idx;
            y_valid <= 1'b1;
            ptr     <= gnt_idx + 2'd1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

`ifdef MUX4_RR_GRANT_CNT_EN
    logic [7:0] cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if (load && cnt[gnt_idx] != 8'hFF) begin
            cnt[gnt_idx] <= cnt[gnt_idx] + 8'd1;
        end
    end

    assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_mux4_rr_arb_reg.sv
// Directed bench for mux4_rr_arb_reg: independent arbitration model plus expected-beat queue.
module tb_mux4_rr_arb_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b, c, d;
    logic       a_valid, b_valid, c_valid, d_valid;
    logic       a_ready, b_ready, c_ready, d_ready;
    logic [7:0] y;
    logic [1:0] y_sel;
    logic       y_valid;
    logic       y_ready;
`ifdef MUX4_RR_GRANT_CNT_EN
    logic [31:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    mux4_rr_arb_reg #(.BUS_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .c_valid   (c_valid),
        .d_valid   (d_valid),
        .a_ready   (a_ready),
        .b_ready   (b_ready),
        .c_ready   (c_ready),
        .d_ready   (d_ready),
        .y         (y),
        .y_sel     (y_sel),
        .y_valid   (y_valid),
`ifdef MUX4_RR_GRANT_CNT_EN
        .grant_cnt (grant_cnt),
`endif
        .y_ready   (y_ready)
    );

    int ncheck = 0;
    int nfail  = 0;

    // reference state
    logic [1:0] m_ptr;
    logic       m_valid;
    logic [7:0] m_y;
    logic [1:0] m_sel;
    logic [9:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncheck++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic yr);
        {d_valid, c_valid, b_valid, a_valid} = v;
        y_ready = yr;
    endtask

    task automatic model_reset();
        m_ptr   = 2'd0;
        m_valid = 1'b0;
        m_y     = 8'h00;
        m_sel   = 2'd0;
        sb.delete();
    endtask

    task automatic do_reset(input string tag, input int ncyc);
        rst_n = 1'b0;
        #1;
        chk({tag, " ready"}, {28'd0, d_ready, c_ready, b_ready, a_ready}, 32'd0);
        repeat (ncyc) @(posedge clk);
        #1;
        chk({tag, " y"},       {24'd0, y},     32'd0);
        chk({tag, " y_sel"},   {30'd0, y_sel}, 32'd0);
        chk({tag, " y_valid"}, {31'd0, y_valid}, 32'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    // One clock: predict grant from the model, check readys, then check the registered result.
    task automatic cyc(input string tag);
        logic [3:0] v;
        logic [7:0] dat [4];
        logic       any;
        logic       ld;
        logic [1:0] g;
        logic [9:0] e;
        int         idx;
        #1;
        v      = {d_valid, c_valid, b_valid, a_valid};
        dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = d;
        any    = 1'b0;
        g      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = (int'(m_ptr) + k) % 4;
            if (!any && v[idx]) begin
                any = 1'b1;
                g   = 2'(idx);
            end
        end
        ld = (!m_valid || y_ready) && any;
        chk({tag, " ready"}, {28'd0, d_ready, c_ready, b_ready, a_ready},
            ld ? (32'd1 << g) : 32'd0);
        if (ld) sb.push_back({g, dat[g]});
        @(posedge clk);
        #1;
        if (ld) begin
            e       = sb.pop_front();
            m_y     = e[7:0];
            m_sel   = e[9:8];
            m_valid = 1'b1;
            m_ptr   = g + 2'd1;
        end else if (y_ready) begin
            m_valid = 1'b0;
        end
        chk({tag, " y_valid"}, {31'd0, y_valid}, {31'd0, m_valid});
        chk({tag, " y"},       {24'd0, y},       {24'd0, m_y});
        chk({tag, " y_sel"},   {30'd0, y_sel},   {30'd0, m_sel});
    endtask

    logic [7:0] rr_y [5];
    logic [1:0] rr_s [5];

    initial begin
        rst_n = 1'b0;
        a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
        drive(4'b1111, 1'b1);
        model_reset();

        // reset with every producer requesting
        do_reset("reset", 2);

        // fairness: 11,22,33,44,11 back-to-back
        rr_y[0] = 8'h11; rr_y[1] = 8'h22; rr_y[2] = 8'h33; rr_y[3] = 8'h44; rr_y[4] = 8'h11;
        rr_s[0] = 2'd0;  rr_s[1] = 2'd1;  rr_s[2] = 2'd2;  rr_s[3] = 2'd3;  rr_s[4] = 2'd0;
        for (int i = 0; i < 5; i++) begin
            cyc("rr");
            chk("rr fixed y",     {24'd0, y},     {24'd0, rr_y[i]});
            chk("rr fixed y_sel", {30'd0, y_sel}, {30'd0, rr_s[i]});
            chk("rr fixed valid", {31'd0, y_valid}, 32'd1);
        end

        // ptr=1 -> grant c alone to move ptr to 3
        drive(4'b0100, 1'b1);
        cyc("to_ptr3");
        // skip and wrap: only a and c
        drive(4'b0101, 1'b1);
        cyc("wrap1");
        chk("wrap1 sel", {30'd0, y_sel}, 32'd0);
        cyc("wrap2");
        chk("wrap2 sel", {30'd0, y_sel}, 32'd2);
        cyc("wrap3");
        chk("wrap3 sel", {30'd0, y_sel}, 32'd0);

        // backpressure
        a = 8'hA5;
        drive(4'b0001, 1'b1);
        cyc("bp_load");
        chk("bp_load y", {24'd0, y}, 32'hA5);
        b = 8'h5A;
        drive(4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc("bp_stall");
            chk("bp_stall y", {24'd0, y}, 32'hA5);
        end
        drive(4'b0010, 1'b1);
        cyc("bp_release");
        chk("bp_release y", {24'd0, y}, 32'h5A);
        chk("bp_release valid", {31'd0, y_valid}, 32'd1);

        // mid-stream reset with y=33, ptr=3
        a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
        drive(4'b1111, 1'b1);
        cyc("pre_rst");
        chk("pre_rst y", {24'd0, y}, 32'h33);
        y_ready = 1'b0;
        do_reset("midrst", 1);
        drive(4'b1111, 1'b1);
        cyc("post_rst");
        chk("post_rst sel", {30'd0, y_sel}, 32'd0);

        // drain with no new requests, then idle keeps ptr
        drive(4'b0000, 1'b1);
        cyc("drain");
        cyc("idle");
        drive(4'b1111, 1'b1);
        cyc("after_idle");
        chk("after_idle sel", {30'd0, y_sel}, 32'd1);

`ifdef MUX4_RR_GRANT_CNT_EN
        do_reset("cnt_rst", 1);
        chk("cnt cleared", grant_cnt, 32'd0);
        drive(4'b1000, 1'b1);
        for (int i = 0; i < 300; i++) cyc("sat");
        chk("grant_cnt sat", grant_cnt, 32'hFF00_0000);
`endif

        $display("%0d/%0d checks passed", ncheck - nfail, ncheck);
        $finish;
    end

endmodule
